// File: rtl/debug_run_controller.sv
// debug_run_controller
// Host-driven run control for the pipelined core. Command bytes from a UART
// receiver freeze, single-step or free-run the core; a DUMP command sweeps PC,
// the 32 registers, MEM_WORDS data-memory words and a run-cycle counter, and
// streams each word MSB-first as 4 bytes to a UART transmitter.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_rx_data/i_rx_valid  received command byte and its one-cycle strobe
//   i_tx_busy/i_tx_done   transmitter busy level and byte-done strobe
//   o_tx_data/o_tx_start  byte to send and its one-cycle start request
//   i_halt                core has retired a HALT instruction (level)
//   i_pc                  current fetch PC
//   i_reg_data            register-file debug read data
//   i_mem_data            data-memory debug read data (one-cycle latency)
//   o_debug               1 = core frozen
//   o_step                one-cycle advance pulse while frozen
//   o_reg_sel/o_rfsel     register-file debug index and port-steal enable
//   o_mem_addr            data-memory debug byte address
//   o_halted              sticky HALT-seen flag
module debug_run_controller #(
  parameter int unsigned NB_BITS   = 32,
  parameter int unsigned NB_REG    = 5,
  parameter int unsigned NB_ADDR   = 10,
  parameter int unsigned MEM_WORDS = 16,
  parameter logic [7:0]  CMD_RUN   = 8'h01,
  parameter logic [7:0]  CMD_STEP  = 8'h02,
  parameter logic [7:0]  CMD_HALT  = 8'h03,
  parameter logic [7:0]  CMD_DUMP  = 8'h04
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_busy,
  input  logic               i_tx_done,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic               i_halt,
  input  logic [NB_BITS-1:0] i_pc,
  input  logic [NB_BITS-1:0] i_reg_data,
  input  logic [NB_BITS-1:0] i_mem_data,
  output logic               o_debug,
  output logic               o_step,
  output logic [NB_REG-1:0]  o_reg_sel,
  output logic               o_rfsel,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic               o_halted
);

  localparam int unsigned LastIdxInt = MEM_WORDS + 33;
  localparam int unsigned NbIdx      = $clog2(LastIdxInt + 1);

  localparam logic [NbIdx-1:0] IdxOne    = NbIdx'(1);
  localparam logic [NbIdx-1:0] IdxRegLast = NbIdx'(32);
  localparam logic [NbIdx-1:0] IdxMemLo  = NbIdx'(33);
  localparam logic [NbIdx-1:0] IdxLast   = NbIdx'(LastIdxInt);

  typedef enum logic [2:0] {
    StIdle, StRun, StStep, StDumpLoad, StDumpWait, StDumpSend, StDumpAck
  } state_e;

  state_e           state_q, state_d;
  logic [NbIdx-1:0] idx_q, idx_d;
  logic [31:0]      shift_q, shift_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      cycle_q, cycle_d;
  logic             halted_q, halted_d;

  logic             is_reg, is_mem, dumping;
  logic [NbIdx-1:0] reg_off, mem_off;
  logic [31:0]      dump_src;

  // Word-index decode: 0 = PC, 1..32 = registers, then memory, then counter.
  always_comb begin
    is_reg  = (idx_q >= IdxOne) && (idx_q <= IdxRegLast);
    is_mem  = (idx_q >= IdxMemLo) && (idx_q < IdxLast);
    reg_off = idx_q - IdxOne;
    mem_off = idx_q - IdxMemLo;
    dumping = (state_q == StDumpLoad) || (state_q == StDumpWait) ||
              (state_q == StDumpSend) || (state_q == StDumpAck);
    if (idx_q == '0) begin
      dump_src = 32'(i_pc);
    end else if (is_reg) begin
      dump_src = 32'(i_reg_data);
    end else if (is_mem) begin
      dump_src = 32'(i_mem_data);
    end else begin
      dump_src = cycle_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_q      <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      cycle_q    <= '0;
      halted_q   <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      cycle_q    <= cycle_d;
      halted_q   <= halted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    cycle_d    = cycle_q;
    halted_d   = halted_q;

    // Counter measures cycles the core actually advanced; wraps naturally.
    if ((state_q == StRun) || (state_q == StStep)) begin
      cycle_d = cycle_q + 32'd1;
    end

    case (state_q)
      StIdle: begin
        if (i_rx_valid) begin
          if ((i_rx_data == CMD_RUN) && !halted_q) begin
            state_d = StRun;
          end else if ((i_rx_data == CMD_STEP) && !halted_q) begin
            state_d = StStep;
          end else if (i_rx_data == CMD_DUMP) begin
            state_d = StDumpLoad;
            idx_d   = '0;
          end
        end
      end
      StRun: begin
        if (i_halt) begin
          halted_d = 1'b1;
          state_d  = StIdle;
        end else if (i_rx_valid && (i_rx_data == CMD_HALT)) begin
          state_d = StIdle;
        end
      end
      StStep:     state_d = StIdle;
      StDumpLoad: state_d = StDumpWait;  // selects settle, memory read in flight
      StDumpWait: begin
        shift_d    = dump_src;
        byte_cnt_d = '0;
        state_d    = StDumpSend;
      end
      StDumpSend: begin
        if (!i_tx_busy) begin
          state_d = StDumpAck;
        end
      end
      StDumpAck: begin
        if (i_tx_done) begin
          shift_d    = {shift_q[23:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (idx_q == IdxLast) begin
              idx_d   = '0;
              state_d = StIdle;
            end else begin
              idx_d   = idx_q + IdxOne;
              state_d = StDumpLoad;
            end
          end else begin
            state_d = StDumpSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from registered state so reset forces them at once.
  always_comb begin
    o_debug    = (state_q != StRun);
    o_step     = (state_q == StStep);
    o_tx_start = (state_q == StDumpSend) && !i_tx_busy;
    o_tx_data  = shift_q[31:24];
    o_rfsel    = dumping && is_reg;
    o_reg_sel  = is_reg ? NB_REG'(reg_off) : '0;
    o_mem_addr = is_mem ? {(NB_ADDR-2)'(mem_off), 2'b00} : '0;
    o_halted   = halted_q;
  end

endmodule

// File: tb/tb_debug_run_controller.sv
module tb_debug_run_controller;

  localparam int unsigned MemWords  = 16;
  localparam int unsigned DumpBytes = 4 * (MemWords + 34);
  localparam logic [7:0]  CmdRun    = 8'h01;
  localparam logic [7:0]  CmdStep   = 8'h02;
  localparam logic [7:0]  CmdHalt   = 8'h03;
  localparam logic [7:0]  CmdDump   = 8'h04;

  logic        i_clk;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        i_tx_busy;
  logic        i_tx_done;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_halt;
  logic [31:0] i_pc;
  logic [31:0] i_reg_data;
  logic [31:0] i_mem_data;
  logic        o_debug;
  logic        o_step;
  logic [4:0]  o_reg_sel;
  logic        o_rfsel;
  logic [9:0]  o_mem_addr;
  logic        o_halted;

  debug_run_controller #(
    .NB_BITS  (32),
    .NB_REG   (5),
    .NB_ADDR  (10),
    .MEM_WORDS(MemWords),
    .CMD_RUN  (CmdRun),
    .CMD_STEP (CmdStep),
    .CMD_HALT (CmdHalt),
    .CMD_DUMP (CmdDump)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_rx_data (i_rx_data),
    .i_rx_valid(i_rx_valid),
    .i_tx_busy (i_tx_busy),
    .i_tx_done (i_tx_done),
    .o_tx_data (o_tx_data),
    .o_tx_start(o_tx_start),
    .i_halt    (i_halt),
    .i_pc      (i_pc),
    .i_reg_data(i_reg_data),
    .i_mem_data(i_mem_data),
    .o_debug   (o_debug),
    .o_step    (o_step),
    .o_reg_sel (o_reg_sel),
    .o_rfsel   (o_rfsel),
    .o_mem_addr(o_mem_addr),
    .o_halted  (o_halted)
  );

  int errors    = 0;
  int n_checks  = 0;
  int n_starts  = 0;
  int n_step    = 0;
  int n_dbg_low = 0;
  logic hold_req = 1'b0;
  logic [7:0] sb[$];

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Core-side models: combinational register file (reg r = r*0x11), memory with
  // one-cycle read latency (word j = 0xA000_0000 + j).
  assign i_reg_data = 32'(o_reg_sel) * 32'h11;
  always @(posedge i_clk) i_mem_data <= 32'hA000_0000 + 32'(o_mem_addr[9:2]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) sb.push_back(w[31-8*b -: 8]);
  endtask

  task automatic push_dump(input logic [31:0] pc, input logic [31:0] cyc);
    push_word(pc);
    for (int r = 0; r < 32; r++) push_word(32'(r) * 32'h11);
    for (int j = 0; j < int'(MemWords); j++) push_word(32'hA000_0000 + 32'(j));
    push_word(cyc);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
  endtask

  task automatic wait_dump(input string name);
    for (int i = 0; i < 6000; i++) begin
      @(posedge i_clk);
      if (sb.size() == 0) break;
    end
    chk({name, "_pending_bytes"}, 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (10) @(posedge i_clk);
    #1;
  endtask

  task automatic wait_starts(input int target, input string name);
    for (int i = 0; i < 4000; i++) begin
      @(posedge i_clk);
      if (n_starts >= target) break;
    end
    chk({name, "_start_count"}, 32'(n_starts >= target), 32'd1);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_debug"}, 32'(o_debug), 32'd1);
    chk({name, "_step"}, 32'(o_step), 32'd0);
    chk({name, "_tx_start"}, 32'(o_tx_start), 32'd0);
    chk({name, "_tx_data"}, 32'(o_tx_data), 32'd0);
    chk({name, "_reg_sel"}, 32'(o_reg_sel), 32'd0);
    chk({name, "_rfsel"}, 32'(o_rfsel), 32'd0);
    chk({name, "_mem_addr"}, 32'(o_mem_addr), 32'd0);
    chk({name, "_halted"}, 32'(o_halted), 32'd0);
  endtask

  // Transmitter model: busy for a few cycles after each start, then a done
  // strobe; optionally keeps busy high 20 more cycles after one byte.
  initial begin
    i_tx_busy = 1'b0;
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_tx_start) begin
        @(posedge i_clk); #1;
        i_tx_busy = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_tx_done = 1'b1;
        @(posedge i_clk); #1;
        i_tx_done = 1'b0;
        if (hold_req) begin
          hold_req = 1'b0;
          repeat (20) @(posedge i_clk);
          #1;
        end
        i_tx_busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every transmit request.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge i_clk);
      if (o_step) n_step++;
      if (!o_debug) n_dbg_low++;
      if (o_tx_start) begin
        n_starts++;
        chk("start_while_busy", 32'(i_tx_busy), 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h, required no byte", o_tx_data);
        end else begin
          exp_b = sb.pop_front();
          chk($sformatf("tx_byte_%0d", n_starts), 32'(o_tx_data), 32'(exp_b));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, s0, d0;
    i_rst      = 1'b1;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_halt     = 1'b0;
    i_pc       = 32'h0000_0040;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset("init");
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Plain dump after reset: counter 0.
    b0 = n_starts; d0 = n_dbg_low;
    push_dump(32'h0000_0040, 32'd0);
    send_cmd(CmdDump);
    wait_dump("dump1");
    chk("dump1_bytes", 32'(n_starts - b0), 32'(DumpBytes));
    chk("dump1_rfsel_end", 32'(o_rfsel), 32'd0);
    chk("dump1_debug_held", 32'(n_dbg_low - d0), 32'd0);

    // Three single steps.
    s0 = n_step; d0 = n_dbg_low;
    repeat (3) begin
      send_cmd(CmdStep);
      repeat (3) @(posedge i_clk);
    end
    #1;
    chk("step_pulses", 32'(n_step - s0), 32'd3);
    chk("step_debug_held", 32'(n_dbg_low - d0), 32'd0);
    push_dump(32'h0000_0040, 32'd3);
    send_cmd(CmdDump);
    wait_dump("dump_step");

    // Fresh reset, RUN then HALT byte 10 cycles later.
    @(posedge i_clk); #1 i_rst = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b0;
    i_pc = 32'h1234_5678;
    d0 = n_dbg_low;
    send_cmd(CmdRun);
    repeat (8) @(posedge i_clk);
    send_cmd(CmdHalt);
    repeat (3) @(posedge i_clk);
    #1;
    chk("run_debug_low_cycles", 32'(n_dbg_low - d0), 32'd10);
    chk("run_debug_back", 32'(o_debug), 32'd1);
    push_dump(32'h1234_5678, 32'd10);
    send_cmd(CmdDump);
    wait_dump("dump_run");

    // RUN stopped by the core's HALT after 5 cycles.
    d0 = n_dbg_low;
    send_cmd(CmdRun);
    repeat (4) @(posedge i_clk);
    #1 i_halt = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("halt_sticky", 32'(o_halted), 32'd1);
    chk("halt_debug", 32'(o_debug), 32'd1);
    chk("halt_run_cycles", 32'(n_dbg_low - d0), 32'd5);
    s0 = n_step; d0 = n_dbg_low;
    send_cmd(CmdRun);
    repeat (3) @(posedge i_clk);
    send_cmd(CmdStep);
    repeat (3) @(posedge i_clk);
    #1;
    chk("halted_run_ignored", 32'(n_dbg_low - d0), 32'd0);
    chk("halted_step_ignored", 32'(n_step - s0), 32'd0);

    // Dump with transmitter stalled mid-word and a STEP byte injected.
    s0 = n_step; b0 = n_starts;
    push_dump(32'h1234_5678, 32'd15);
    send_cmd(CmdDump);
    wait_starts(b0 + 6, "hold");
    hold_req = 1'b1;
    send_cmd(CmdStep);
    wait_dump("dump_hold");
    chk("dump_hold_step_dropped", 32'(n_step - s0), 32'd0);
    chk("dump_hold_bytes", 32'(n_starts - b0), 32'(DumpBytes));

    // Reset during the third byte of word 5.
    i_halt = 1'b0;
    i_pc   = 32'h0000_0040;
    b0 = n_starts;
    push_dump(32'h0000_0040, 32'd15);
    send_cmd(CmdDump);
    wait_starts(b0 + 23, "pre_reset");
    #1 i_rst = 1'b1;
    #1;
    check_reset("mid_dump_reset");
    sb.delete();
    @(posedge i_clk); #1 i_rst = 1'b0;
    repeat (40) @(posedge i_clk);
    #1;
    chk("reset_abandoned_bytes", 32'(n_starts - b0), 32'd23);
    sb.delete();
    b0 = n_starts;
    push_dump(32'h0000_0040, 32'd0);
    send_cmd(CmdDump);
    wait_dump("dump_after_reset");
    chk("dump_after_reset_bytes", 32'(n_starts - b0), 32'(DumpBytes));
    chk("dump_after_reset_rfsel", 32'(o_rfsel), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
